// File: rtl/lt24_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// lt24_pixel_sequencer
//
// Turns single-pixel write requests (x, y, RGB565) into the ILI9341 word stream
// consumed by the LT24 bus driver. Every pixel sets a one-pixel window and then
// writes one colour word:
//   Column Address Set (0x2A) : cmd, 0x0000, x, 0x0000, x
//   Page Address Set   (0x2B) : cmd, y[8], y[7:0], y[8], y[7:0]
//   Memory Write       (0x2C) : cmd, pixelData
// With SKIP_REDUNDANT set, a column or page group is left out when its
// coordinate matches the value most recently sent to the panel.
//
// Ports
//   clock, resetn       : rising-edge clock, asynchronous active-low reset
//   xAddr, yAddr        : pixel column (8 bits) / row (9 bits)
//   pixelData           : RGB565 colour
//   pixelWrite          : request valid, held by upstream until accepted
//   pixelReady          : request can be accepted (idle only)
//   pixelDone           : one-cycle pulse after the colour word is accepted
//   pixelError          : one-cycle pulse when an out-of-range request is dropped
//   cmdWrite            : word valid towards the LT24 driver
//   cmdIsCommand        : 1 = command word (DC low), 0 = data word
//   cmdData             : word to send
//   cmdReady            : driver takes the word on cmdWrite && cmdReady
// -----------------------------------------------------------------------------
module lt24_pixel_sequencer #(
    parameter int LCD_WIDTH      = 240,
    parameter int LCD_HEIGHT     = 320,
    parameter bit SKIP_REDUNDANT = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        pixelDone,
    output logic        pixelError,
    output logic        cmdWrite,
    output logic        cmdIsCommand,
    output logic [15:0] cmdData,
    input  logic        cmdReady
);

    // Limits widened by one bit so the comparison cannot wrap.
    localparam logic [8:0]  X_LIMIT   = 9'(LCD_WIDTH);
    localparam logic [9:0]  Y_LIMIT   = 10'(LCD_HEIGHT);

    localparam logic [15:0] CMD_CASET = 16'h002A;
    localparam logic [15:0] CMD_PASET = 16'h002B;
    localparam logic [15:0] CMD_RAMWR = 16'h002C;

    // CHECK is the single cycle in which the registered request is range-tested.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_COL   = 3'd2,
        S_PAGE  = 3'd3,
        S_MEMW  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_r;
    logic [2:0]  wordIdx_r;
    logic [7:0]  xAddr_r;
    logic [8:0]  yAddr_r;
    logic [15:0] pixel_r;
    logic [7:0]  xCache_r;
    logic [8:0]  yCache_r;
    logic        xCacheValid_r;
    logic        yCacheValid_r;

    logic        pixelReady_r;
    logic        pixelDone_r;
    logic        pixelError_r;
    logic        cmdWrite_r;
    logic        cmdIsCommand_r;
    logic [15:0] cmdData_r;

    logic        rangeOk_s;
    logic        skipCol_s;
    logic        skipPage_s;
    state_t      firstGroup_s;
    state_t      nextGroup_s;
    logic [2:0]  lastIdx_s;
    logic        handshake_s;

    // Word for position idx of a group, returned as {isCommand, data}.
    // Data words carry their significant bits in [7:0] with zeroed upper bits,
    // except the colour word which is a full 16-bit value.
    function automatic logic [16:0] groupWord(
        input state_t      grp,
        input logic [2:0]  idx,
        input logic [7:0]  x,
        input logic [8:0]  y,
        input logic [15:0] d
    );
        logic [16:0] word;
        word = 17'h0_0000;
        case (grp)
            S_COL: begin
                case (idx)
                    3'd0:       word = {1'b1, CMD_CASET};
                    3'd2, 3'd4: word = {1'b0, 8'h00, x};
                    default:    word = {1'b0, 16'h0000};
                endcase
            end
            S_PAGE: begin
                case (idx)
                    3'd0:       word = {1'b1, CMD_PASET};
                    3'd1, 3'd3: word = {1'b0, 15'h0000, y[8]};
                    3'd2, 3'd4: word = {1'b0, 8'h00, y[7:0]};
                    default:    word = {1'b0, 16'h0000};
                endcase
            end
            S_MEMW: begin
                case (idx)
                    3'd0:    word = {1'b1, CMD_RAMWR};
                    default: word = {1'b0, d};
                endcase
            end
            default: word = 17'h0_0000;
        endcase
        return word;
    endfunction

    // Range test and cache-hit detection on the registered request.
    always_comb begin
        rangeOk_s  = ({1'b0, xAddr_r} < X_LIMIT) && ({1'b0, yAddr_r} < Y_LIMIT);
        skipCol_s  = SKIP_REDUNDANT && xCacheValid_r && (xCache_r == xAddr_r);
        skipPage_s = SKIP_REDUNDANT && yCacheValid_r && (yCache_r == yAddr_r);
        handshake_s = cmdWrite_r && cmdReady;
    end

    // First group to emit after a passing range check; colour write is never skipped.
    always_comb begin
        firstGroup_s = S_COL;
        if (!skipCol_s) begin
            firstGroup_s = S_COL;
        end else if (!skipPage_s) begin
            firstGroup_s = S_PAGE;
        end else begin
            firstGroup_s = S_MEMW;
        end
    end

    // Group that follows the current one once its last word is accepted.
    always_comb begin
        nextGroup_s = S_DONE;
        case (state_r)
            S_COL:   nextGroup_s = skipPage_s ? S_MEMW : S_PAGE;
            S_PAGE:  nextGroup_s = S_MEMW;
            default: nextGroup_s = S_DONE;
        endcase
    end

    // Index of the final word in the current group.
    always_comb begin
        lastIdx_s = 3'd4;
        if (state_r == S_MEMW) begin
            lastIdx_s = 3'd1;
        end else begin
            lastIdx_s = 3'd4;
        end
    end

    // Sequencer FSM with registered handshake outputs and coordinate caches.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r        <= S_IDLE;
            wordIdx_r      <= 3'd0;
            xAddr_r        <= 8'h00;
            yAddr_r        <= 9'h000;
            pixel_r        <= 16'h0000;
            xCache_r       <= 8'h00;
            yCache_r       <= 9'h000;
            xCacheValid_r  <= 1'b0;
            yCacheValid_r  <= 1'b0;
            pixelReady_r   <= 1'b1;
            pixelDone_r    <= 1'b0;
            pixelError_r   <= 1'b0;
            cmdWrite_r     <= 1'b0;
            cmdIsCommand_r <= 1'b0;
            cmdData_r      <= 16'h0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    pixelDone_r  <= 1'b0;
                    pixelError_r <= 1'b0;
                    if (pixelWrite && pixelReady_r) begin
                        xAddr_r      <= xAddr;
                        yAddr_r      <= yAddr;
                        pixel_r      <= pixelData;
                        pixelReady_r <= 1'b0;
                        state_r      <= S_CHECK;
                    end else begin
                        state_r      <= S_IDLE;
                    end
                end

                S_CHECK: begin
                    if (!rangeOk_s) begin
                        // Dropped request: nothing reaches the panel, caches untouched.
                        pixelError_r <= 1'b1;
                        pixelReady_r <= 1'b1;
                        state_r      <= S_IDLE;
                    end else begin
                        state_r      <= firstGroup_s;
                        wordIdx_r    <= 3'd0;
                        cmdWrite_r   <= 1'b1;
                        {cmdIsCommand_r, cmdData_r} <=
                            groupWord(firstGroup_s, 3'd0, xAddr_r, yAddr_r, pixel_r);
                    end
                end

                S_COL, S_PAGE, S_MEMW: begin
                    if (handshake_s) begin
                        if (wordIdx_r != lastIdx_s) begin
                            wordIdx_r <= 3'(wordIdx_r + 3'd1);
                            {cmdIsCommand_r, cmdData_r} <=
                                groupWord(state_r, 3'(wordIdx_r + 3'd1), xAddr_r, yAddr_r, pixel_r);
                        end else begin
                            // Cache only once the whole window group has gone out.
                            if (state_r == S_COL) begin
                                xCache_r      <= xAddr_r;
                                xCacheValid_r <= 1'b1;
                            end else if (state_r == S_PAGE) begin
                                yCache_r      <= yAddr_r;
                                yCacheValid_r <= 1'b1;
                            end else begin
                                xCacheValid_r <= xCacheValid_r;
                            end
                            state_r   <= nextGroup_s;
                            wordIdx_r <= 3'd0;
                            if (nextGroup_s == S_DONE) begin
                                cmdWrite_r  <= 1'b0;
                                pixelDone_r <= 1'b1;
                            end else begin
                                {cmdIsCommand_r, cmdData_r} <=
                                    groupWord(nextGroup_s, 3'd0, xAddr_r, yAddr_r, pixel_r);
                            end
                        end
                    end else begin
                        // Stalled: hold the presented word unchanged.
                        state_r <= state_r;
                    end
                end

                S_DONE: begin
                    pixelDone_r  <= 1'b0;
                    pixelReady_r <= 1'b1;
                    state_r      <= S_IDLE;
                end

                default: begin
                    state_r      <= S_IDLE;
                    wordIdx_r    <= 3'd0;
                    pixelReady_r <= 1'b1;
                    pixelDone_r  <= 1'b0;
                    pixelError_r <= 1'b0;
                    cmdWrite_r   <= 1'b0;
                end
            endcase
        end
    end

    assign pixelReady   = pixelReady_r;
    assign pixelDone    = pixelDone_r;
    assign pixelError   = pixelError_r;
    assign cmdWrite     = cmdWrite_r;
    assign cmdIsCommand = cmdIsCommand_r;
    assign cmdData      = cmdData_r;

endmodule

// File: tb/tb_lt24_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lt24_pixel_sequencer
//
// Directed bench for lt24_pixel_sequencer. Two instances share clock, reset,
// pixel fields and cmdReady: the default one (redundant groups skipped) and
// one with SKIP_REDUNDANT=0, each with its own pixelWrite.
// -----------------------------------------------------------------------------
module tb_lt24_pixel_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelWrite2;
    logic        cmdReady;
    logic        stallMode;

    logic        pixelReady,  pixelDone,  pixelError,  cmdWrite,  cmdIsCommand;
    logic [15:0] cmdData;
    logic        pixelReady2, pixelDone2, pixelError2, cmdWrite2, cmdIsCommand2;
    logic [15:0] cmdData2;

    int checkCount = 0;
    int errCount   = 0;
    int cyc        = 0;

    // Observation queues, filled by the monitors and cleared before each request.
    logic [16:0] wq0[$], wq1[$];
    int          wc0[$], wc1[$];
    int          stallQ0[$], stallQ1[$];
    int          doneQ0[$], doneQ1[$];
    int          errQ0[$], errQ1[$];
    int          unstable0[$], unstable1[$];
    logic        stallPrev0, stallPrev1;
    logic [16:0] heldWord0, heldWord1;

    logic [16:0] expQ[$];

    lt24_pixel_sequencer u_dut (
        .clock(clock), .resetn(resetn),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
        .pixelReady(pixelReady), .pixelDone(pixelDone), .pixelError(pixelError),
        .cmdWrite(cmdWrite), .cmdIsCommand(cmdIsCommand), .cmdData(cmdData),
        .cmdReady(cmdReady)
    );

    lt24_pixel_sequencer #(.SKIP_REDUNDANT(1'b0)) u_dutNoSkip (
        .clock(clock), .resetn(resetn),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite2),
        .pixelReady(pixelReady2), .pixelDone(pixelDone2), .pixelError(pixelError2),
        .cmdWrite(cmdWrite2), .cmdIsCommand(cmdIsCommand2), .cmdData(cmdData2),
        .cmdReady(cmdReady)
    );

    // Clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Downstream readiness: always ready, or random stalls while stallMode is set.
    initial begin
        cmdReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (stallMode) cmdReady = ($urandom_range(0, 1) != 0);
            else           cmdReady = 1'b1;
        end
    end

    // Monitor of the skipping instance.
    always @(negedge clock) begin
        if (!resetn) begin
            stallPrev0 <= 1'b0;
        end else begin
            if (stallPrev0 && ({cmdWrite, cmdIsCommand, cmdData} != {1'b1, heldWord0}))
                unstable0.push_back(cyc);
            if (cmdWrite && cmdReady) begin
                wq0.push_back({cmdIsCommand, cmdData});
                wc0.push_back(cyc);
            end
            if (cmdWrite && !cmdReady) stallQ0.push_back(cyc);
            if (pixelDone)  doneQ0.push_back(cyc);
            if (pixelError) errQ0.push_back(cyc);
            stallPrev0 <= cmdWrite && !cmdReady;
            heldWord0  <= {cmdIsCommand, cmdData};
        end
    end

    // Monitor of the non-skipping instance.
    always @(negedge clock) begin
        if (!resetn) begin
            stallPrev1 <= 1'b0;
        end else begin
            if (stallPrev1 && ({cmdWrite2, cmdIsCommand2, cmdData2} != {1'b1, heldWord1}))
                unstable1.push_back(cyc);
            if (cmdWrite2 && cmdReady) begin
                wq1.push_back({cmdIsCommand2, cmdData2});
                wc1.push_back(cyc);
            end
            if (cmdWrite2 && !cmdReady) stallQ1.push_back(cyc);
            if (pixelDone2)  doneQ1.push_back(cyc);
            if (pixelError2) errQ1.push_back(cyc);
            stallPrev1 <= cmdWrite2 && !cmdReady;
            heldWord1  <= {cmdIsCommand2, cmdData2};
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            errCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic clearObs();
        wq0.delete(); wc0.delete(); stallQ0.delete(); doneQ0.delete(); errQ0.delete(); unstable0.delete();
        wq1.delete(); wc1.delete(); stallQ1.delete(); doneQ1.delete(); errQ1.delete(); unstable1.delete();
    endtask

    // Present one request to the chosen instance and wait until it is accepted.
    task automatic sendPixel(input int which, input logic [7:0] x, input logic [8:0] y,
                             input logic [15:0] d, output int acceptCyc);
        int k;
        clearObs();
        k = 0;
        @(negedge clock);
        while (!(which == 0 ? pixelReady : pixelReady2) && k < 50) begin
            @(negedge clock);
            k++;
        end
        checkValue("readyBeforeSend", (which == 0 ? pixelReady : pixelReady2), 1);
        xAddr = x; yAddr = y; pixelData = d;
        if (which == 0) pixelWrite = 1'b1;
        else            pixelWrite2 = 1'b1;
        @(posedge clock);
        #1;
        pixelWrite = 1'b0; pixelWrite2 = 1'b0;
        acceptCyc = cyc;
        checkValue("busyAfterAccept", (which == 0 ? pixelReady : pixelReady2), 0);
    endtask

    // Wait (bounded) for the instance to become ready again.
    task automatic waitReady(input int which, output int readyCyc);
        int k;
        k = 0;
        @(negedge clock);
        while (!(which == 0 ? pixelReady : pixelReady2) && k < 300) begin
            @(negedge clock);
            k++;
        end
        #1;
        checkValue("readyReturns", (which == 0 ? pixelReady : pixelReady2), 1);
        readyCyc = cyc;
    endtask

    task automatic runPixel(input int which, input logic [7:0] x, input logic [8:0] y,
                            input logic [15:0] d, output int acceptCyc, output int readyCyc);
        sendPixel(which, x, y, d, acceptCyc);
        waitReady(which, readyCyc);
    endtask

    // Compare a completed pixel against expQ, including its timing.
    task automatic checkRun(input string tag, input int which, input int acceptCyc, input int readyCyc);
        logic [16:0] w[$];
        int c[$], dn[$], er[$], un[$];
        int s;
        if (which == 0) begin w = wq0; c = wc0; dn = doneQ0; er = errQ0; un = unstable0; s = stallQ0.size(); end
        else            begin w = wq1; c = wc1; dn = doneQ1; er = errQ1; un = unstable1; s = stallQ1.size(); end
        checkValue({tag, ".wordCount"}, w.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++)
            if (i < w.size()) checkValue($sformatf("%s.word%0d", tag, i), w[i], expQ[i]);
        if (s == 0 && c.size() > 0) checkValue({tag, ".firstWordCycle"}, c[0], acceptCyc + 1);
        checkValue({tag, ".doneCount"}, dn.size(), 1);
        if (dn.size() > 0) begin
            checkValue({tag, ".doneCycle"}, dn[0], acceptCyc + 1 + expQ.size() + s);
            checkValue({tag, ".readyCycle"}, readyCyc, dn[0] + 1);
        end
        checkValue({tag, ".errorCount"}, er.size(), 0);
        checkValue({tag, ".holdStable"}, un.size(), 0);
    endtask

    // Check a dropped (out-of-range) request on the skipping instance.
    task automatic checkDrop(input string tag, input int acceptCyc, input int readyCyc);
        checkValue({tag, ".wordCount"}, wq0.size(), 0);
        checkValue({tag, ".errorCount"}, errQ0.size(), 1);
        if (errQ0.size() > 0) checkValue({tag, ".errorCycle"}, errQ0[0], acceptCyc + 1);
        checkValue({tag, ".readyCycle"}, readyCyc, acceptCyc + 1);
        checkValue({tag, ".doneCount"}, doneQ0.size(), 0);
    endtask

    initial begin
        int acc, rdy, k;
        resetn = 1'b0; stallMode = 1'b0;
        xAddr = 8'h00; yAddr = 9'h000; pixelData = 16'h0000;
        pixelWrite = 1'b0; pixelWrite2 = 1'b0;

        // Reset state.
        repeat (2) @(negedge clock);
        checkValue("rst.pixelReady",   pixelReady,   1);
        checkValue("rst.cmdWrite",     cmdWrite,     0);
        checkValue("rst.cmdIsCommand", cmdIsCommand, 0);
        checkValue("rst.cmdData",      cmdData,      0);
        checkValue("rst.pixelDone",    pixelDone,    0);
        checkValue("rst.pixelError",   pixelError,   0);
        resetn = 1'b1;

        // Full sequence from cold caches.
        runPixel(0, 8'd10, 9'd20, 16'hF800, acc, rdy);
        expQ = '{17'h1002A, 17'h00000, 17'h0000A, 17'h00000, 17'h0000A,
                 17'h1002B, 17'h00000, 17'h00014, 17'h00000, 17'h00014,
                 17'h1002C, 17'h0F800};
        checkRun("full", 0, acc, rdy);

        // Same column: column group skipped.
        runPixel(0, 8'd10, 9'd21, 16'hF800, acc, rdy);
        expQ = '{17'h1002B, 17'h00000, 17'h00015, 17'h00000, 17'h00015,
                 17'h1002C, 17'h0F800};
        checkRun("skipCol", 0, acc, rdy);

        // Largest legal coordinates, high row bit set.
        runPixel(0, 8'd239, 9'd319, 16'h07E0, acc, rdy);
        expQ = '{17'h1002A, 17'h00000, 17'h000EF, 17'h00000, 17'h000EF,
                 17'h1002B, 17'h00001, 17'h0003F, 17'h00001, 17'h0003F,
                 17'h1002C, 17'h007E0};
        checkRun("maxCoord", 0, acc, rdy);

        // Out of range in x, then in y.
        runPixel(0, 8'd240, 9'd5, 16'h1111, acc, rdy);
        checkDrop("xOver", acc, rdy);
        runPixel(0, 8'd239, 9'd320, 16'h2222, acc, rdy);
        checkDrop("yOver", acc, rdy);

        // Caches survived the dropped requests: only the colour write remains.
        runPixel(0, 8'd239, 9'd319, 16'h001F, acc, rdy);
        expQ = '{17'h1002C, 17'h0001F};
        checkRun("cacheKept", 0, acc, rdy);

        // Random downstream stalls: same words, stretched timing, stable hold.
        stallMode = 1'b1;
        runPixel(0, 8'd10, 9'd20, 16'hF800, acc, rdy);
        stallMode = 1'b0;
        expQ = '{17'h1002A, 17'h00000, 17'h0000A, 17'h00000, 17'h0000A,
                 17'h1002B, 17'h00000, 17'h00014, 17'h00000, 17'h00014,
                 17'h1002C, 17'h0F800};
        checkRun("stalled", 0, acc, rdy);

        // Reset in the middle of the page group.
        sendPixel(0, 8'd50, 9'd60, 16'h1234, acc);
        k = 0;
        while (!(cmdWrite && cmdIsCommand && cmdData == 16'h002B) && k < 40) begin
            @(negedge clock);
            k++;
        end
        checkValue("midReset.reachedPage", cmdData, 16'h002B);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        checkValue("midReset.cmdWrite",   cmdWrite,   0);
        checkValue("midReset.pixelReady", pixelReady, 1);
        checkValue("midReset.cmdData",    cmdData,    0);
        checkValue("midReset.noDone",     doneQ0.size(), 0);
        @(negedge clock);
        resetn = 1'b1;

        // Same column again: cache was invalidated, full sequence returns.
        runPixel(0, 8'd50, 9'd60, 16'h1234, acc, rdy);
        expQ = '{17'h1002A, 17'h00000, 17'h00032, 17'h00000, 17'h00032,
                 17'h1002B, 17'h00000, 17'h0003C, 17'h00000, 17'h0003C,
                 17'h1002C, 17'h01234};
        checkRun("afterReset", 0, acc, rdy);

        // Non-skipping instance: identical pixel twice, all words both times.
        expQ = '{17'h1002A, 17'h00000, 17'h0000A, 17'h00000, 17'h0000A,
                 17'h1002B, 17'h00000, 17'h00014, 17'h00000, 17'h00014,
                 17'h1002C, 17'h0F800};
        runPixel(1, 8'd10, 9'd20, 16'hF800, acc, rdy);
        checkRun("noSkip1", 1, acc, rdy);
        runPixel(1, 8'd10, 9'd20, 16'hF800, acc, rdy);
        checkRun("noSkip2", 1, acc, rdy);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errCount, checkCount);
        $fatal(1);
    end

endmodule
